// File: rtl/ps2_mouse_tracker_if.sv
// Byte-stream input and cursor/button outputs of the PS/2 mouse tracker.
interface ps2_mouse_tracker_if #(
  parameter int POS_W   = 10,
  parameter int WHEEL_W = 8
);
  logic                      rx_done;
  logic [7:0]                rx_data;
  logic [POS_W-1:0]          x_pos;
  logic [POS_W-1:0]          y_pos;
  logic signed [WHEEL_W-1:0] wheel_pos;
  logic                      click_l;
  logic                      click_r;
  logic                      click_m;
  logic                      packet_done;
  logic                      sync_err;

  // Receiver side: feeds bytes, observes the tracked state.
  modport master (
    output rx_done, rx_data,
    input  x_pos, y_pos, wheel_pos, click_l, click_r, click_m, packet_done, sync_err
  );

  // Tracker side: consumes bytes, drives the tracked state.
  modport slave (
    input  rx_done, rx_data,
    output x_pos, y_pos, wheel_pos, click_l, click_r, click_m, packet_done, sync_err
  );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and cursor tracker: frames 3/4-byte packets,
// resyncs on bad header or inter-byte timeout, integrates scaled deltas
// into a clamped screen position and a saturating wheel accumulator.
module ps2_mouse_tracker #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int WHEEL_EN   = 0,
  parameter int POS_W      = 10,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int SHIFT      = 0,
  parameter int WHEEL_W    = 8
) (
  input logic                 clk,
  input logic                 reset,
  ps2_mouse_tracker_if.slave  bus
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int CNT_W  = $clog2(TO_CYC + 1);
  localparam int CW     = POS_W + 2;

  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TO_CYC - 1);
  localparam logic signed [CW-1:0]   X_MAX_S  = CW'(X_MAX);
  localparam logic signed [CW-1:0]   Y_MAX_S  = CW'(Y_MAX);
  localparam logic [POS_W-1:0]       X_INIT_V = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]       Y_INIT_V = POS_W'(Y_INIT);

  typedef enum logic [2:0] {
    S_B0  = 3'd0,
    S_B1  = 3'd1,
    S_B2  = 3'd2,
    S_B3  = 3'd3,
    S_UPD = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  // Header byte without its always-one bit 3: {y_ovf, x_ovf, y_sgn, x_sgn, m, r, l}
  logic [6:0]                hdr_q, hdr_d;
  logic [7:0]                b1_q, b1_d;
  logic [7:0]                b2_q, b2_d;
  logic [POS_W-1:0]          x_q, x_d;
  logic [POS_W-1:0]          y_q, y_d;
  logic signed [WHEEL_W-1:0] wheel_q, wheel_d;
  logic [2:0]                btn_q, btn_d;
  logic                      sync_err_q, sync_err_d;

  logic [7:0]                dy_byte;
  logic signed [8:0]         dx_s, dy_s;
  logic signed [CW-1:0]      x_sum, y_sum;
  logic signed [WHEEL_W:0]   w_sum;
  logic [POS_W-1:0]          x_new, y_new;
  logic signed [WHEEL_W-1:0] w_new;
  logic                      timeout;

  // 9-bit delta from sign + byte; overflow flag forces the extreme value.
  function automatic logic signed [8:0] delta(input logic ovf, input logic sgn,
                                              input logic [7:0] b);
    if (ovf) return sgn ? 9'h100 : 9'h0FF;
    return {sgn, b};
  endfunction

  // Sensitivity scaling keeps the sign (floor toward -inf).
  function automatic logic signed [8:0] scale(input logic signed [8:0] d);
    return d >>> SHIFT;
  endfunction

  function automatic logic signed [CW-1:0] sext9(input logic signed [8:0] d);
    return {{(CW-9){d[8]}}, d};
  endfunction

  // Clamp a signed candidate position into [0, vmax].
  function automatic logic [POS_W-1:0] clamp(input logic signed [CW-1:0] v,
                                             input logic signed [CW-1:0] vmax);
    if (v[CW-1])   return '0;
    if (v > vmax)  return vmax[POS_W-1:0];
    return v[POS_W-1:0];
  endfunction

  // Saturate a one-bit-wider sum to the signed WHEEL_W range.
  function automatic logic signed [WHEEL_W-1:0] wsat(input logic signed [WHEEL_W:0] v);
    if (v[WHEEL_W] != v[WHEEL_W-1])
      return v[WHEEL_W] ? {1'b1, {(WHEEL_W-1){1'b0}}} : {1'b0, {(WHEEL_W-1){1'b1}}};
    return v[WHEEL_W-1:0];
  endfunction

  // New position/wheel candidates; the final byte of the packet is taken live from rx_data.
  always_comb begin
    dy_byte = (WHEEL_EN != 0) ? b2_q : bus.rx_data;
    dx_s    = scale(delta(hdr_q[5], hdr_q[3], b1_q));
    dy_s    = scale(delta(hdr_q[6], hdr_q[4], dy_byte));
    x_sum   = $signed({2'b00, x_q}) + sext9(dx_s);
    y_sum   = $signed({2'b00, y_q}) - sext9(dy_s);
    x_new   = clamp(x_sum, X_MAX_S);
    y_new   = clamp(y_sum, Y_MAX_S);
    w_sum   = $signed({wheel_q[WHEEL_W-1], wheel_q})
            + $signed({{(WHEEL_W-3){bus.rx_data[3]}}, bus.rx_data[3:0]});
    w_new   = wsat(w_sum);
    timeout = (cnt_q == CNT_LAST);
  end

  // Packet framing FSM: byte capture, resync, timeout and output commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    x_d        = x_q;
    y_d        = y_q;
    wheel_d    = wheel_q;
    btn_d      = btn_q;
    sync_err_d = 1'b0;
    case (state_q)
      S_B0, S_UPD: begin
        state_d = S_B0;
        if (bus.rx_done) begin
          if (bus.rx_data[3]) begin
            hdr_d   = {bus.rx_data[7:4], bus.rx_data[2:0]};
            state_d = S_B1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      S_B1: begin
        if (bus.rx_done) begin
          b1_d    = bus.rx_data;
          state_d = S_B2;
        end else if (timeout) begin
          state_d    = S_B0;
          sync_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_B2: begin
        if (bus.rx_done) begin
          if (WHEEL_EN != 0) begin
            b2_d    = bus.rx_data;
            state_d = S_B3;
          end else begin
            x_d     = x_new;
            y_d     = y_new;
            btn_d   = hdr_q[2:0];
            state_d = S_UPD;
          end
        end else if (timeout) begin
          state_d    = S_B0;
          sync_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_B3: begin
        if (bus.rx_done) begin
          x_d     = x_new;
          y_d     = y_new;
          wheel_d = w_new;
          btn_d   = hdr_q[2:0];
          state_d = S_UPD;
        end else if (timeout) begin
          state_d    = S_B0;
          sync_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_B0;
    endcase
  end

  // Control state and visible outputs, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_B0;
      cnt_q      <= '0;
      x_q        <= X_INIT_V;
      y_q        <= Y_INIT_V;
      wheel_q    <= '0;
      btn_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wheel_q    <= wheel_d;
      btn_q      <= btn_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Packet byte holding registers; only read after being written in the same packet.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
    b1_q  <= b1_d;
    b2_q  <= b2_d;
  end

  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.wheel_pos   = wheel_q;
  assign bus.click_l     = btn_q[0];
  assign bus.click_r     = btn_q[1];
  assign bus.click_m     = btn_q[2];
  assign bus.packet_done = (state_q == S_UPD);
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: dut_a is the 3-byte variant,
// dut_b the wheel variant with SHIFT=1. Drivers push hand-computed
// expectations; per-DUT monitors pop them on packet_done/sync_err.
module tb_ps2_mouse_tracker;

  localparam int TO = 40;  // 1 MHz clock figure x 40 us

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit err;
    int x;
    int y;
    int w;
    int btn;
    int after;
    int due_off;
    int due;
  } exp_t;
  typedef exp_t       exp_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  exp_t sba[$];
  exp_t sbb[$];

  ps2_mouse_tracker_if #(.POS_W(10), .WHEEL_W(8)) ifa ();
  ps2_mouse_tracker_if #(.POS_W(10), .WHEEL_W(8)) ifb ();

  ps2_mouse_tracker #(
    .CLK_HZ(1_000_000), .TIMEOUT_US(TO), .WHEEL_EN(0), .POS_W(10),
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .SHIFT(0), .WHEEL_W(8)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

  ps2_mouse_tracker #(
    .CLK_HZ(1_000_000), .TIMEOUT_US(TO), .WHEEL_EN(1), .POS_W(10),
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .SHIFT(1), .WHEEL_W(8)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int w, input int btn,
                              input int after);
    exp_t e;
    e.err = 1'b0; e.x = x; e.y = y; e.w = w; e.btn = btn;
    e.after = after; e.due_off = 1; e.due = 0;
    return e;
  endfunction

  function automatic exp_t mkerr(input int after, input int due_off);
    exp_t e;
    e.err = 1'b1; e.x = 0; e.y = 0; e.w = 0; e.btn = 0;
    e.after = after; e.due_off = due_off; e.due = 0;
    return e;
  endfunction

  // Drive bytes on consecutive cycles; push each expectation once its trigger byte is sampled.
  task automatic stream(input bit d, input byte_q_t bs, input exp_q_t es);
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < bs.size(); i++) begin
      if (d) begin ifb.rx_done = 1'b1; ifb.rx_data = bs[i]; end
      else   begin ifa.rx_done = 1'b1; ifa.rx_data = bs[i]; end
      @(posedge clk);
      for (int k = 0; k < es.size(); k++) begin
        if (es[k].after == i) begin
          e = es[k];
          e.due = cyc + e.due_off;
          if (d) sbb.push_back(e); else sba.push_back(e);
        end
      end
      #1;
    end
    if (d) ifb.rx_done = 1'b0; else ifa.rx_done = 1'b0;
  endtask

  task automatic pkt(input bit d, input int n, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [7:0] b3,
                     input int x, input int y, input int w, input int btn);
    byte_q_t bs;
    exp_q_t  es;
    bs.push_back(b0); bs.push_back(b1); bs.push_back(b2);
    if (n == 4) bs.push_back(b3);
    es.push_back(mk(x, y, w, btn, n - 1));
    stream(d, bs, es);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic chk_reset(input bit d);
    if (d) begin
      chk("b_rst_x", ifb.x_pos, 320);         chk("b_rst_y", ifb.y_pos, 240);
      chk("b_rst_wheel", ifb.wheel_pos, 0);
      chk("b_rst_btn", {ifb.click_m, ifb.click_r, ifb.click_l}, 0);
      chk("b_rst_pd", ifb.packet_done, 0);    chk("b_rst_se", ifb.sync_err, 0);
    end else begin
      chk("a_rst_x", ifa.x_pos, 320);         chk("a_rst_y", ifa.y_pos, 240);
      chk("a_rst_wheel", ifa.wheel_pos, 0);
      chk("a_rst_btn", {ifa.click_m, ifa.click_r, ifa.click_l}, 0);
      chk("a_rst_pd", ifa.packet_done, 0);    chk("a_rst_se", ifa.sync_err, 0);
    end
  endtask

  task automatic observe(input bit d, input logic pd, input logic se, input int x,
                         input int y, input int w, input int btn);
    exp_t  e;
    string t;
    t = d ? "b" : "a";
    chk({t, "_pulse_exclusive"}, int'(pd & se), 0);
    if ((d ? sbb.size() : sba.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_event: got pd=%0d se=%0d, expected no event (cycle %0d)",
               t, pd, se, cyc);
    end else begin
      e = d ? sbb.pop_front() : sba.pop_front();
      chk({t, "_event_kind_se"}, int'(se), int'(e.err));
      chk({t, "_event_cycle"}, cyc, e.due);
      if (!e.err) begin
        chk({t, "_x"}, x, e.x);
        chk({t, "_y"}, y, e.y);
        chk({t, "_wheel"}, w, e.w);
        chk({t, "_buttons"}, btn, e.btn);
      end
    end
  endtask

  always @(negedge clk)
    if (reset && (ifa.packet_done || ifa.sync_err))
      observe(1'b0, ifa.packet_done, ifa.sync_err, ifa.x_pos, ifa.y_pos, ifa.wheel_pos,
              {ifa.click_m, ifa.click_r, ifa.click_l});

  always @(negedge clk)
    if (reset && (ifb.packet_done || ifb.sync_err))
      observe(1'b1, ifb.packet_done, ifb.sync_err, ifb.x_pos, ifb.y_pos, ifb.wheel_pos,
              {ifb.click_m, ifb.click_r, ifb.click_l});

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected $finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t bs;
    exp_q_t  es;
    int      w;
    ifa.rx_done = 1'b0; ifa.rx_data = 8'h00;
    ifb.rx_done = 1'b0; ifb.rx_data = 8'h00;

    do_reset();
    chk_reset(1'b0);
    chk_reset(1'b1);

    // basic +10 in x
    pkt(0, 3, 8'h08, 8'h0A, 8'h00, 8'h00, 330, 240, 0, 0);
    do_reset();
    chk_reset(1'b0);

    // negative x, then positive y moves the cursor up
    pkt(0, 3, 8'h18, 8'hF6, 8'h00, 8'h00, 310, 240, 0, 0);
    pkt(0, 3, 8'h08, 8'h00, 8'h05, 8'h00, 310, 235, 0, 0);

    // walk to x=635, then clamp at X_MAX
    pkt(0, 3, 8'h08, 8'h7F, 8'h00, 8'h00, 437, 235, 0, 0);
    pkt(0, 3, 8'h08, 8'h7F, 8'h00, 8'h00, 564, 235, 0, 0);
    pkt(0, 3, 8'h08, 8'h47, 8'h00, 8'h00, 635, 235, 0, 0);
    pkt(0, 3, 8'h08, 8'h0A, 8'h00, 8'h00, 639, 235, 0, 0);
    // y to 2, down 16 to 18, to 10, then clamp at 0
    pkt(0, 3, 8'h08, 8'h00, 8'hE9, 8'h00, 639, 2, 0, 0);
    pkt(0, 3, 8'h28, 8'h00, 8'hF0, 8'h00, 639, 18, 0, 0);
    pkt(0, 3, 8'h08, 8'h00, 8'h08, 8'h00, 639, 10, 0, 0);
    pkt(0, 3, 8'h08, 8'h00, 8'h20, 8'h00, 639, 0, 0, 0);
    // overflow flags: x saturates to -256, y to -256 (moves down)
    pkt(0, 3, 8'h58, 8'h05, 8'h00, 8'h00, 383, 0, 0, 0);
    pkt(0, 3, 8'hA8, 8'h00, 8'h07, 8'h00, 383, 256, 0, 0);

    // bad header byte discarded, then a good packet with left click
    bs.delete(); es.delete();
    bs.push_back(8'h00); es.push_back(mkerr(0, 1));
    stream(0, bs, es);
    pkt(0, 3, 8'h09, 8'h05, 8'h00, 8'h00, 388, 256, 0, 1);

    // back-to-back packets: next header arrives during the update cycle
    bs.delete(); es.delete();
    bs.push_back(8'h0A); bs.push_back(8'h01); bs.push_back(8'h00);
    bs.push_back(8'h0C); bs.push_back(8'h02); bs.push_back(8'h00);
    es.push_back(mk(389, 256, 0, 2, 2));
    es.push_back(mk(391, 256, 0, 4, 5));
    stream(0, bs, es);

    // inter-byte timeout aborts the partial packet
    bs.delete(); es.delete();
    bs.push_back(8'h08); bs.push_back(8'h05);
    es.push_back(mkerr(1, TO + 1));
    stream(0, bs, es);
    repeat (TO + 10) @(posedge clk);
    pkt(0, 3, 8'h08, 8'h03, 8'h00, 8'h00, 394, 256, 0, 0);

    // y sign set: dy = -251, clamps at Y_MAX
    pkt(0, 3, 8'h28, 8'h00, 8'h05, 8'h00, 394, 479, 0, 0);

    // wheel variant, SHIFT=1
    pkt(1, 4, 8'h08, 8'h14, 8'h00, 8'h0F, 330, 240, -1, 0);
    pkt(1, 4, 8'h18, 8'hFD, 8'h00, 8'h00, 328, 240, -1, 0);
    for (int k = 1; k <= 127; k++) begin
      w = -1 + 7 * k;
      if (w > 127) w = 127;
      pkt(1, 4, 8'h08, 8'h00, 8'h00, 8'h07, 328, 240, w, 0);
    end
    pkt(1, 4, 8'h08, 8'h00, 8'h00, 8'hF8, 328, 240, 119, 0);

    // reset in the middle of a packet
    bs.delete(); es.delete();
    bs.push_back(8'h08); bs.push_back(8'h05);
    stream(1, bs, es);
    do_reset();
    chk_reset(1'b1);
    pkt(1, 4, 8'h08, 8'h02, 8'h00, 8'h00, 321, 240, 0, 0);
    pkt(1, 4, 8'h08, 8'h00, 8'h09, 8'h00, 321, 236, 0, 0);

    for (int i = 0; i < 200 && (sba.size() != 0 || sbb.size() != 0); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("a_scoreboard_drained", sba.size(), 0);
    chk("b_scoreboard_drained", sbb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
